// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Sequences a single-ported data memory between load requests (that missed
//   store forwarding) and retired-store writebacks from the LSQ head. One
//   request is in flight at a time; loads return through a fixed-latency read
//   path to the writeback bus. Loads younger than a mispredicting branch are
//   killed, but their memory cycle still completes.
//
// Ports
//   clk, reset_n                   clock (rising edge), async active-low reset
//   ld_req_* / ld_req_ready        load request handshake (addr, pd, rob)
//   st_req_* / st_req_ready        store request handshake (addr, data, rob)
//   mispredict, mispredict_tag     branch mispredict pulse and branch ROB tag
//   rob_head                       current ROB head, reference for age compare
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata           data memory macro interface
//   ld_done, ld_data, ld_pd, ld_rob load writeback (1-cycle pulse)
//   st_done, st_rob                store commit (1-cycle pulse)
//   busy                           FSM not in IDLE
//
// Optional build macro: MEM_ARB_STATS_EN
//   Adds stat_ld_grants, stat_st_grants, stat_ld_kills (16-bit wrapping
//   counters of load grants, store grants and load kills).

module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ROB_W        = 5,
  parameter int unsigned PREG_W       = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req_valid,
  input  logic [31:0]       ld_req_addr,
  input  logic [PREG_W-1:0] ld_req_pd,
  input  logic [ROB_W-1:0]  ld_req_rob,
  output logic              ld_req_ready,
  input  logic              st_req_valid,
  input  logic [31:0]       st_req_addr,
  input  logic [31:0]       st_req_data,
  input  logic [ROB_W-1:0]  st_req_rob,
  output logic              st_req_ready,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic [ROB_W-1:0]  rob_head,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              ld_done,
  output logic [31:0]       ld_data,
  output logic [PREG_W-1:0] ld_pd,
  output logic [ROB_W-1:0]  ld_rob,
  output logic              st_done,
  output logic [ROB_W-1:0]  st_rob,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ld_grants,
  output logic [15:0]       stat_st_grants,
  output logic [15:0]       stat_ld_kills
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    LD_WAIT = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          starve_cnt;
  logic [2:0]          lat_cnt;
  logic                is_load;
  logic                kill;
  logic [PREG_W-1:0]   req_pd;
  logic [ROB_W-1:0]    req_rob;

  // Ages relative to the ROB head; modular subtraction handles wrap.
  logic [ROB_W-1:0]    br_age;
  logic [ROB_W-1:0]    ld_age;
  logic [ROB_W-1:0]    q_age;
  logic                ld_young_kill;
  logic                q_young_kill;
  logic                starve_hit;
  logic                idle_ok;
  logic                ld_acc;
  logic                st_acc;
  logic                kill_next;
  logic                last_next;
  logic                kill_evt;

  assign br_age        = mispredict_tag - rob_head;
  assign ld_age        = ld_req_rob - rob_head;
  assign q_age         = req_rob - rob_head;
  assign ld_young_kill = mispredict && (ld_age > br_age);
  assign q_young_kill  = mispredict && (q_age > br_age);
  assign starve_hit    = (starve_cnt == 4'(STARVE_LIMIT));

  // Ready is gated by reset_n so every output reads 0 while reset is held.
  assign idle_ok      = reset_n && (state == IDLE);
  assign ld_req_ready = idle_ok && ld_req_valid && !ld_young_kill &&
                        (!st_req_valid || starve_hit);
  assign st_req_ready = idle_ok && !ld_req_ready;
  assign ld_acc       = ld_req_valid && ld_req_ready;
  assign st_acc       = st_req_valid && st_req_ready;

  assign kill_next = kill || q_young_kill;

  // True when the coming cycle is the final LD_WAIT cycle, i.e. the cycle in
  // which mem_rdata is valid; ld_done is registered one edge ahead of it.
  assign last_next = (state == ISSUE && is_load && MEM_LATENCY == 32'd1) ||
                     (state == LD_WAIT && lat_cnt == 3'd1);

  // A kill is only recorded while it can still suppress ld_done.
  assign kill_evt = is_load && !kill && q_young_kill &&
                    (state == ISSUE || (state == LD_WAIT && lat_cnt != 3'd0));

  // Read data is valid in the pulse cycle itself, so pass it straight through.
  assign ld_data = ld_done ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      is_load    <= 1'b0;
      kill       <= 1'b0;
      req_pd     <= '0;
      req_rob    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ld_done    <= 1'b0;
      ld_pd      <= '0;
      ld_rob     <= '0;
      st_done    <= 1'b0;
      st_rob     <= '0;
      busy       <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      ld_done <= 1'b0;
      st_done <= 1'b0;
      if (!ld_req_valid) begin
        starve_cnt <= '0;
      end
      case (state)
        IDLE: begin
          if (ld_acc) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            is_load    <= 1'b1;
            kill       <= 1'b0;
            mem_en     <= 1'b1;
            mem_addr   <= ld_req_addr;
            mem_wdata  <= '0;
            req_pd     <= ld_req_pd;
            req_rob    <= ld_req_rob;
            starve_cnt <= '0;
          end else if (st_acc) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            is_load   <= 1'b0;
            kill      <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= st_req_addr;
            mem_wdata <= st_req_data;
            req_rob   <= st_req_rob;
            st_done   <= 1'b1;
            st_rob    <= st_req_rob;
            if (ld_req_valid && !starve_hit) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE: begin
          if (is_load) begin
            state   <= LD_WAIT;
            lat_cnt <= 3'(MEM_LATENCY - 1);
            kill    <= kill_next;
            ld_done <= last_next && !kill_next;
            if (last_next) begin
              ld_pd  <= req_pd;
              ld_rob <= req_rob;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LD_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            kill  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
            kill    <= kill_next;
            ld_done <= last_next && !kill_next;
            if (last_next) begin
              ld_pd  <= req_pd;
              ld_rob <= req_rob;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ld_grants <= '0;
      stat_st_grants <= '0;
      stat_ld_kills  <= '0;
    end else begin
      if (ld_acc) begin
        stat_ld_grants <= stat_ld_grants + 16'd1;
      end
      if (st_acc) begin
        stat_st_grants <= stat_st_grants + 16'd1;
      end
      if (kill_evt) begin
        stat_ld_kills <= stat_ld_kills + 16'd1;
      end
    end
  end
`else
  logic unused_kill_evt;
  assign unused_kill_evt = kill_evt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic [6:0]  ld_req_pd;
  logic [4:0]  ld_req_rob;
  logic        ld_req_ready;
  logic        st_req_valid;
  logic [31:0] st_req_addr;
  logic [31:0] st_req_data;
  logic [4:0]  st_req_rob;
  logic        st_req_ready;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic [4:0]  rob_head;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic [31:0] ld_data;
  logic [6:0]  ld_pd;
  logic [4:0]  ld_rob;
  logic        st_done;
  logic [4:0]  st_rob;
  logic        busy;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_ld_grants;
  logic [15:0] stat_st_grants;
  logic [15:0] stat_ld_kills;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .MEM_LATENCY (2),
    .STARVE_LIMIT(4),
    .ROB_W       (5),
    .PREG_W      (7)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ld_req_valid  (ld_req_valid),
    .ld_req_addr   (ld_req_addr),
    .ld_req_pd     (ld_req_pd),
    .ld_req_rob    (ld_req_rob),
    .ld_req_ready  (ld_req_ready),
    .st_req_valid  (st_req_valid),
    .st_req_addr   (st_req_addr),
    .st_req_data   (st_req_data),
    .st_req_rob    (st_req_rob),
    .st_req_ready  (st_req_ready),
    .mispredict    (mispredict),
    .mispredict_tag(mispredict_tag),
    .rob_head      (rob_head),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .ld_done       (ld_done),
    .ld_data       (ld_data),
    .ld_pd         (ld_pd),
    .ld_rob        (ld_rob),
    .st_done       (st_done),
    .st_rob        (st_rob),
    .busy          (busy)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_ld_grants(stat_ld_grants),
    .stat_st_grants(stat_st_grants),
    .stat_ld_kills (stat_ld_kills)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro: read data valid exactly 2 cycles after the mem_en cycle,
  // garbage otherwise so a mistimed capture is visible.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h80) return 32'h12345678;
    return {a[15:0], ~a[15:0]};
  endfunction

  logic        rd_v0, rd_v1;
  logic [31:0] rd_d0, rd_d1;
  always @(posedge clk) begin
    rd_v1 <= rd_v0;
    rd_d1 <= rd_d0;
    rd_v0 <= mem_en && !mem_we;
    rd_d0 <= mem_fn(mem_addr);
  end
  assign mem_rdata = rd_v1 ? rd_d1 : 32'hBAD0BAD0;

  // Cycle-wide invariants.
  always @(negedge clk) begin
    if (reset_n) begin
      n_cmp++;
      if (ld_req_ready && st_req_ready) begin
        n_fail++;
        $display("FAIL both_ready: ld_req_ready=%b st_req_ready=%b, required not both 1", ld_req_ready, st_req_ready);
      end
      n_cmp++;
      if (st_done !== (mem_en && mem_we)) begin
        n_fail++;
        $display("FAIL st_done_pulse: st_done=%b, required %b", st_done, mem_en && mem_we);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_en: got %b, required 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_we: got %b, required 0", mem_we); end
    n_cmp++; if (ld_done !== 1'b0) begin n_fail++; $display("FAIL rst_ld_done: got %b, required 0", ld_done); end
    n_cmp++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL rst_st_done: got %b, required 0", st_done); end
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_cmp++; if (st_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_st_ready: got %b, required 0", st_req_ready); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, required 0", mem_addr); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (st_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_st_ready: got %b, required 1", st_req_ready); end
    n_cmp++; if (ld_req_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_ld_ready: got %b, required 0", ld_req_ready); end
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    st_req_valid = 1'b1; st_req_addr = 32'h40; st_req_data = 32'hDEADBEEF; st_req_rob = 5'd3;
    @(negedge clk);
    n_cmp++; if (st_req_ready !== 1'b1) begin n_fail++; $display("FAIL st_ready: got %b, required 1", st_req_ready); end
    @(posedge clk); #1;
    st_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL st_mem_en: got %b, required 1", mem_en); end
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL st_mem_we: got %b, required 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL st_mem_addr: got %h, required 00000040", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st_mem_wdata: got %h, required deadbeef", mem_wdata); end
    n_cmp++; if (st_done !== 1'b1) begin n_fail++; $display("FAIL st_done: got %b, required 1", st_done); end
    n_cmp++; if (st_rob !== 5'd3) begin n_fail++; $display("FAIL st_rob: got %0d, required 3", st_rob); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL st_busy: got %b, required 1", busy); end
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL st_mem_en_drop: got %b, required 0", mem_en); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy_drop: got %b, required 0", busy); end
  endtask

  task automatic test_load();
    @(posedge clk); #1;
    rob_head = 5'd0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h80; ld_req_pd = 7'd9; ld_req_rob = 5'd5;
    @(negedge clk);
    n_cmp++; if (ld_req_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready: got %b, required 1", ld_req_ready); end
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    @(negedge clk);  // T+1
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ld_issue: mem_en=%b mem_we=%b, required 1/0", mem_en, mem_we); end
    n_cmp++; if (mem_addr !== 32'h80) begin n_fail++; $display("FAIL ld_mem_addr: got %h, required 00000080", mem_addr); end
    @(negedge clk);  // T+2
    n_cmp++; if (ld_done !== 1'b0) begin n_fail++; $display("FAIL ld_done_early: got %b, required 0", ld_done); end
    @(negedge clk);  // T+3
    n_cmp++; if (ld_done !== 1'b1) begin n_fail++; $display("FAIL ld_done: got %b, required 1", ld_done); end
    n_cmp++; if (ld_data !== 32'h12345678) begin n_fail++; $display("FAIL ld_data: got %h, required 12345678", ld_data); end
    n_cmp++; if (ld_pd !== 7'd9) begin n_fail++; $display("FAIL ld_pd: got %0d, required 9", ld_pd); end
    n_cmp++; if (ld_rob !== 5'd5) begin n_fail++; $display("FAIL ld_rob: got %0d, required 5", ld_rob); end
    @(negedge clk);  // T+4
    n_cmp++; if (ld_done !== 1'b0) begin n_fail++; $display("FAIL ld_done_late: got %b, required 0", ld_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ld_busy_end: got %b, required 0", busy); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    st_req_valid = 1'b1; st_req_addr = 32'h100; st_req_data = 32'h11111111; st_req_rob = 5'd6;
    @(posedge clk); #1;  // first accepted
    st_req_addr = 32'h104; st_req_data = 32'h22222222; st_req_rob = 5'd7;
    @(negedge clk);
    n_cmp++; if (mem_wdata !== 32'h11111111 || mem_en !== 1'b1) begin n_fail++; $display("FAIL b2b_first: mem_en=%b wdata=%h, required 1/11111111", mem_en, mem_wdata); end
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b0 || st_req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: mem_en=%b st_req_ready=%b, required 0/1", mem_en, st_req_ready); end
    @(posedge clk); #1;  // second accepted
    st_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_wdata !== 32'h22222222 || mem_addr !== 32'h104) begin n_fail++; $display("FAIL b2b_second: addr=%h wdata=%h, required 00000104/22222222", mem_addr, mem_wdata); end
    n_cmp++; if (st_rob !== 5'd7) begin n_fail++; $display("FAIL b2b_st_rob: got %0d, required 7", st_rob); end
  endtask

  // Both requesters held high: 4 store grants then a load, twice in a row
  // without dropping the load request, so the second round only shows 4
  // stores again if the load grant cleared the counter.
  task automatic test_starvation();
    @(posedge clk); #1;
    rob_head = 5'd0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h200; ld_req_pd = 7'd1; ld_req_rob = 5'd1;
    st_req_valid = 1'b1; st_req_addr = 32'h300; st_req_data = 32'h55; st_req_rob = 5'd8;
    for (int i = 0; i < 10; i++) begin
      int k;
      logic exp_ld;
      exp_ld = (i == 4 || i == 9);
      k = 0;
      @(negedge clk);
      while (!(ld_req_ready || st_req_ready) && k < 10) begin
        @(negedge clk);
        k++;
      end
      n_cmp++;
      if (k >= 10 || ld_req_ready !== exp_ld) begin
        n_fail++;
        $display("FAIL starve_grant%0d: ld_req_ready=%b, required %b", i, ld_req_ready, exp_ld);
      end
      @(posedge clk); #1;
      if (i == 9) begin
        ld_req_valid = 1'b0;
        st_req_valid = 1'b0;
      end
    end
    wait_idle("starve");
  endtask

  task automatic test_kill(input logic [4:0] tag, input logic exp_done);
    @(posedge clk); #1;
    rob_head = 5'd30;
    ld_req_valid = 1'b1; ld_req_addr = 32'h84; ld_req_pd = 7'd4; ld_req_rob = 5'd2;
    @(posedge clk); #1;  // accepted (state IDLE, no competitor)
    ld_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL kill%0d_issue: mem_en=%b, required 1", tag, mem_en); end
    @(posedge clk); #1;  // LD_WAIT
    mispredict = 1'b1; mispredict_tag = tag;
    @(posedge clk); #1;
    mispredict = 1'b0;
    @(negedge clk);
    n_cmp++; if (ld_done !== exp_done) begin n_fail++; $display("FAIL kill%0d_ld_done: got %b, required %b", tag, ld_done, exp_done); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kill%0d_busy: got %b, required 1", tag, busy); end
    if (exp_done) begin
      n_cmp++; if (ld_data !== 32'h0084FF7B) begin n_fail++; $display("FAIL kill%0d_ld_data: got %h, required 0084ff7b", tag, ld_data); end
      n_cmp++; if (ld_rob !== 5'd2) begin n_fail++; $display("FAIL kill%0d_ld_rob: got %0d, required 2", tag, ld_rob); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ld_done !== 1'b0) begin n_fail++; $display("FAIL kill%0d_end: busy=%b ld_done=%b, required 0/0", tag, busy, ld_done); end
  endtask

  task automatic test_kill_on_accept();
    @(posedge clk); #1;
    rob_head = 5'd30;
    ld_req_valid = 1'b1; ld_req_addr = 32'h88; ld_req_pd = 7'd2; ld_req_rob = 5'd2;
    mispredict = 1'b1; mispredict_tag = 5'd0;
    @(negedge clk);
    n_cmp++; if (ld_req_ready !== 1'b0) begin n_fail++; $display("FAIL accept_kill_young: ld_req_ready=%b, required 0", ld_req_ready); end
    mispredict_tag = 5'd4;  // branch now younger than the load
    #1;
    n_cmp++; if (ld_req_ready !== 1'b1) begin n_fail++; $display("FAIL accept_kill_old: ld_req_ready=%b, required 1", ld_req_ready); end
    ld_req_valid = 1'b0;
    mispredict = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1;
    rob_head = 5'd0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h80; ld_req_pd = 7'd3; ld_req_rob = 5'd4;
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    @(posedge clk); #1;  // LD_WAIT
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_now: busy=%b mem_en=%b, required 0/0", busy, mem_en); end
    n_cmp++; if (ld_done !== 1'b0 || ld_data !== 32'h0) begin n_fail++; $display("FAIL midrst_ld: ld_done=%b ld_data=%h, required 0/0", ld_done, ld_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ld_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_after%0d: ld_done=%b busy=%b, required 0/0", i, ld_done, busy);
      end
    end
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic stat_store(input logic [4:0] rob);
    @(posedge clk); #1;
    st_req_valid = 1'b1; st_req_addr = 32'h500; st_req_data = 32'h77; st_req_rob = rob;
    @(posedge clk); #1;
    st_req_valid = 1'b0;
    wait_idle("stat_st");
  endtask

  task automatic stat_load(input logic do_kill);
    @(posedge clk); #1;
    rob_head = 5'd30;
    ld_req_valid = 1'b1; ld_req_addr = 32'h80; ld_req_pd = 7'd5; ld_req_rob = 5'd2;
    @(posedge clk); #1;
    ld_req_valid = 1'b0;
    @(posedge clk); #1;
    mispredict = do_kill; mispredict_tag = 5'd0;
    @(posedge clk); #1;
    mispredict = 1'b0;
    wait_idle("stat_ld");
  endtask

  task automatic test_stats();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    stat_store(5'd1);
    stat_load(1'b0);
    stat_store(5'd2);
    stat_load(1'b1);
    stat_store(5'd3);
    @(negedge clk);
    n_cmp++; if (stat_st_grants !== 16'd3) begin n_fail++; $display("FAIL stat_st: got %0d, required 3", stat_st_grants); end
    n_cmp++; if (stat_ld_grants !== 16'd2) begin n_fail++; $display("FAIL stat_ld: got %0d, required 2", stat_ld_grants); end
    n_cmp++; if (stat_ld_kills !== 16'd1)  begin n_fail++; $display("FAIL stat_kill: got %0d, required 1", stat_ld_kills); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_pd = '0; ld_req_rob = '0;
    st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_rob = '0;
    mispredict = 1'b0; mispredict_tag = '0; rob_head = '0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    wait_idle("b2b");
    test_starvation();
    test_kill(5'd0, 1'b0);
    test_kill(5'd4, 1'b1);
    test_kill_on_accept();
    test_reset_mid_load();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
